// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Definitions shared by the DDS SPI master and the DDS SPI receiver. Keeping
// them in one place stops the two ends of the link from disagreeing on the
// frame layout.
//   - register address map (FREQ0/FREQ1/PHASE0/PHASE1)
//   - frame geometry: ADDR_W address bits followed by DATA_W data bits
//   - serializer state encoding
// -----------------------------------------------------------------------------
package dds_pkg;

  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 24;
  localparam int FRAME_W = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] ADDR_FREQ0  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_FREQ1  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PHASE0 = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_PHASE1 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } ser_state_e;

endpackage

// File: rtl/dds_spi_master_if.sv
// -----------------------------------------------------------------------------
// dds_spi_master_if
// Host-side command handshake of the DDS SPI master.
//   cmd_addr  : target register address
//   cmd_data  : value to write
//   cmd_valid : command offered by the host
//   cmd_ready : master can take a command this cycle
// Modports: master = host side (drives the command), slave = dds_spi_master.
// -----------------------------------------------------------------------------
interface dds_spi_master_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 24
);

  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_valid;
  logic                  cmd_ready;

  modport master (
    output cmd_addr,
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_addr,
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/dds_cmd_fifo.sv
// -----------------------------------------------------------------------------
// dds_cmd_fifo
// Small synchronous command queue placed in front of the SPI serializer when
// DDS_SPI_MASTER_FIFO_EN is defined. Show-ahead: dout is the head entry
// whenever empty is low, so a pop consumes the value seen in the same cycle.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flushes the queue)
//   push, din   : write an entry (ignored when full)
//   pop, dout   : consume the head entry (ignored when empty)
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module dds_cmd_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are valid, and leaving the array out of reset lets it map
  // onto plain RAM/registers without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dds_spi_master.sv
// -----------------------------------------------------------------------------
// dds_spi_master
// Serial transmitter for the DDS configuration port. Each accepted command
// {cmd_addr, cmd_data} is sent as one SPI mode-0 frame, MSB first, inside a
// single chip-select assertion. Every SPI level lasts CLK_DIV clk cycles so
// the receiver's synchronizer and edge detector see all of them.
//
// Ports:
//   clk        : system clock (rising edge)
//   reset      : synchronous, active-high reset
//   cmd        : dds_spi_master_if.slave (cmd_addr/cmd_data/cmd_valid/cmd_ready)
//   busy       : a command is in flight (or queued, with the FIFO build)
//   done       : one-cycle pulse as spi_cs_n rises after a complete frame
//   spi_clock  : SPI clock, idles low
//   spi_cs_n   : chip select, active low
//   spi_mosi   : serial data, changes only while spi_clock is low
//
// Frame timing per command: SETUP (clock low), then alternating SHIFT_HI /
// SHIFT_LO for each bit, HOLD (clock low, CS still low), GAP (CS high).
// Every phase is CLK_DIV cycles, so CS is low for (2F+1)*CLK_DIV cycles.
//
// Build option DDS_SPI_MASTER_FIFO_EN: a 4-entry command FIFO in front of the
// serializer; frames then run back-to-back with a CLK_DIV-cycle CS-high gap.
// -----------------------------------------------------------------------------
module dds_spi_master
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int CLK_DIV    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_spi_master_if.slave      cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 spi_clock,
  output logic                 spi_cs_n,
  output logic                 spi_mosi
);

  localparam int F    = ADDR_WIDTH + DATA_WIDTH;
  localparam int HP_W = $clog2(CLK_DIV);
  localparam int BC_W = $clog2(F);

  // Below 4 cycles per level the receiver's 2-flop synchronizer plus edge
  // detector can miss a level.
  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("dds_spi_master: CLK_DIV must be at least 4");
  end

  ser_state_e       state;
  logic [HP_W-1:0]  hp_cnt;
  logic [BC_W-1:0]  bit_cnt;
  logic [F-1:0]     shreg;
  logic             busy_q;

  logic             hp_last;
  logic             take;
  logic [F-1:0]     take_frame;

  assign hp_last = (hp_cnt == HP_W'(CLK_DIV - 1));

`ifdef DDS_SPI_MASTER_FIFO_EN
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic [F-1:0] fifo_dout;

  assign cmd.cmd_ready = !reset && !fifo_full;
  assign fifo_push     = cmd.cmd_valid && cmd.cmd_ready;

  // The serializer pulls the next frame either from IDLE or straight out of
  // the last GAP cycle, so queued frames keep a gap of exactly CLK_DIV.
  assign take       = !reset && !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_GAP) && hp_last));
  assign take_frame = fifo_dout;
  assign busy       = busy_q || !fifo_empty;

  dds_cmd_fifo #(
    .WIDTH (F),
    .DEPTH (4)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({cmd.cmd_addr, cmd.cmd_data}),
    .pop   (take),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  // cmd_ready is the only combinational output: it must drop in the same
  // cycle reset is asserted so a coincident command is never taken.
  assign cmd.cmd_ready = !reset && (state == ST_IDLE);
  assign take          = cmd.cmd_valid && cmd.cmd_ready;
  assign take_frame    = {cmd.cmd_addr, cmd.cmd_data};
  assign busy          = busy_q;
`endif

  // NOTE: all state and outputs here use non-blocking assignments so every
  // register samples the pre-edge values; blocking assignments would let the
  // order of statements leak into the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hp_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      busy_q    <= 1'b0;
      done      <= 1'b0;
      spi_clock <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (take) begin
        // Frame latched here; later input changes cannot reach it.
        state     <= ST_SETUP;
        hp_cnt    <= '0;
        bit_cnt   <= BC_W'(F - 1);
        shreg     <= take_frame;
        busy_q    <= 1'b1;
        spi_cs_n  <= 1'b0;
        spi_clock <= 1'b0;
        spi_mosi  <= take_frame[F-1];
      end else begin
        if (state != ST_IDLE) begin
          hp_cnt <= hp_last ? '0 : hp_cnt + HP_W'(1);
        end

        case (state)
          ST_IDLE: begin
          end

          ST_SETUP: begin
            if (hp_last) begin
              state     <= ST_SHIFT_HI;
              spi_clock <= 1'b1;
            end
          end

          ST_SHIFT_HI: begin
            if (hp_last) begin
              spi_clock <= 1'b0;
              if (bit_cnt == '0) begin
                state <= ST_HOLD;
              end else begin
                // Next bit is presented on the falling edge so it is stable
                // for the whole low and high phase around the next rise.
                state    <= ST_SHIFT_LO;
                bit_cnt  <= bit_cnt - BC_W'(1);
                shreg    <= {shreg[F-2:0], 1'b0};
                spi_mosi <= shreg[F-2];
              end
            end
          end

          ST_SHIFT_LO: begin
            if (hp_last) begin
              state     <= ST_SHIFT_HI;
              spi_clock <= 1'b1;
            end
          end

          ST_HOLD: begin
            if (hp_last) begin
              state    <= ST_GAP;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              done     <= 1'b1;
            end
          end

          ST_GAP: begin
            if (hp_last) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
